cpu_mc: RTL

//  Parametrised multicycle successor to the single-cycle 8-bit accumulator CPU: same 3-bit-opcode ISA,

---
 rtl/cpu_mc_pkg.sv | 32 +++
 rtl/cpu_mc_alu.sv | 38 +++
 rtl/cpu_mc.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cpu_mc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_mc_pkg : opcodes, FSM state encoding and flag bit indices for cpu_mc
// Revision   : 1.0
// ---------------------------------------------------------------------------
package cpu_mc_pkg;

    localparam logic [2:0] OP_LD  = 3'b000;
    localparam logic [2:0] OP_ST  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_LDI = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_JC  = 3'b111;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;

    function automatic logic is_jump(input logic [2:0] op);
        return (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mc_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_mc_alu : combinational datapath for LD/LDI/ADD/SUB producing {C,Z}
// Revision   : 1.0
// ---------------------------------------------------------------------------
module cpu_mc_alu
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [2:0]        op_i,
    output logic [DATA_W-1:0] res_o,
    output logic [1:0]        flags_o
);

    logic [DATA_W:0] w_wide;

    always_comb begin
        w_wide = {1'b0, y_i};
        case (op_i)
            OP_ADD:  w_wide = {1'b0, x_i} + {1'b0, y_i};
            // The extra top bit of an unsigned subtract is the borrow (x < y).
            OP_SUB:  w_wide = {1'b0, x_i} - {1'b0, y_i};
            default: w_wide = {1'b0, y_i};
        endcase
    end

    always_comb begin
        res_o           = w_wide[DATA_W-1:0];
        flags_o         = 2'b00;
        flags_o[FLAG_C] = w_wide[DATA_W];
        flags_o[FLAG_Z] = (w_wide[DATA_W-1:0] == '0);
    end

endmodule
`default_nettype wire

// File: rtl/cpu_mc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_mc   : multicycle accumulator CPU, FETCH/EXEC/MEM FSM, req/ack memories
// Options  : CPU_MC_STEP_EN adds step_i single-step fetch gating
// Revision : 1.0
// ---------------------------------------------------------------------------
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int ADDR_W  = 5,
    localparam int INSTR_W = 3 + ADDR_W
) (
    input  logic               clk_i,
    input  logic               reset_i,
`ifdef CPU_MC_STEP_EN
    input  logic               step_i,
`endif
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [ADDR_W-1:0]  dmem_addr_o,
    output logic [DATA_W-1:0]  dmem_wdata_o,
    input  logic               dmem_ack_i,
    input  logic [DATA_W-1:0]  dmem_rdata_i,
    output logic [DATA_W-1:0]  acc_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] ir_o,
    output logic [1:0]         flags_o,
    output logic               retire_o,
    output logic               halt_o
);

    state_e               state_q;
    logic [DATA_W-1:0]    acc_q;
    logic [ADDR_W-1:0]    pc_q;
    logic [INSTR_W-1:0]   ir_q;
    logic [1:0]           flags_q;
    logic                 retire_q;
    logic                 halt_q;
`ifdef CPU_MC_STEP_EN
    logic                 pend_q;
`endif

    logic [2:0]           w_op;
    logic [ADDR_W-1:0]    w_arg;
    logic [ADDR_W-1:0]    w_pc_inc;
    logic [DATA_W-1:0]    w_imm;
    logic [DATA_W-1:0]    w_alu_y;
    logic [DATA_W-1:0]    w_alu_res;
    logic [1:0]           w_alu_flags;
    logic                 w_taken;
    logic                 w_fetch_req;

    assign w_op     = ir_q[INSTR_W-1 -: 3];
    assign w_arg    = ir_q[ADDR_W-1:0];
    assign w_pc_inc = pc_q + ADDR_W'(1);
    assign w_imm    = DATA_W'(w_arg);
    assign w_alu_y  = (w_op == OP_LDI) ? w_imm : dmem_rdata_i;

    // Conditional jumps look at the flags left by the preceding instruction.
    assign w_taken = (w_op == OP_JMP)
                  || ((w_op == OP_JZ) && flags_q[FLAG_Z])
                  || ((w_op == OP_JC) && flags_q[FLAG_C]);

`ifdef CPU_MC_STEP_EN
    assign w_fetch_req = (state_q == S_FETCH) && (step_i || pend_q);
`else
    assign w_fetch_req = (state_q == S_FETCH);
`endif

    cpu_mc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .x_i     (acc_q),
        .y_i     (w_alu_y),
        .op_i    (w_op),
        .res_o   (w_alu_res),
        .flags_o (w_alu_flags)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= S_FETCH;
            acc_q    <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            flags_q  <= '0;
            retire_q <= 1'b0;
            halt_q   <= 1'b0;
`ifdef CPU_MC_STEP_EN
            pend_q   <= 1'b0;
`endif
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (w_fetch_req && imem_ack_i) begin
                        ir_q    <= imem_data_i;
                        state_q <= S_EXEC;
`ifdef CPU_MC_STEP_EN
                        pend_q  <= 1'b0;
                    end else if (w_fetch_req) begin
                        pend_q  <= 1'b1;
`endif
                    end
                end
                S_EXEC: begin
                    if (w_op == OP_LDI) begin
                        acc_q    <= w_alu_res;
                        flags_q  <= w_alu_flags;
                        pc_q     <= w_pc_inc;
                        retire_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end else if (is_jump(w_op)) begin
                        retire_q <= 1'b1;
                        if (!w_taken) begin
                            pc_q    <= w_pc_inc;
                            state_q <= S_FETCH;
                        end else if (w_arg == pc_q) begin
                            halt_q  <= 1'b1;
                            state_q <= S_HALT;
                        end else begin
                            pc_q    <= w_arg;
                            state_q <= S_FETCH;
                        end
                    end else begin
                        state_q <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (dmem_ack_i) begin
                        if (w_op != OP_ST) begin
                            acc_q   <= w_alu_res;
                            flags_q <= w_alu_flags;
                        end
                        pc_q     <= w_pc_inc;
                        retire_q <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    // Reset parks the FSM in FETCH, so the fetch request is masked by reset itself.
    assign imem_req_o   = w_fetch_req && reset_i;
    assign imem_addr_o  = pc_q;
    assign dmem_req_o   = (state_q == S_MEM);
    assign dmem_we_o    = (state_q == S_MEM) && (w_op == OP_ST);
    assign dmem_addr_o  = w_arg;
    assign dmem_wdata_o = acc_q;
    assign acc_o        = acc_q;
    assign pc_o         = pc_q;
    assign ir_o         = ir_q;
    assign flags_o      = flags_q;
    assign retire_o     = retire_q;
    assign halt_o       = halt_q;

endmodule
`default_nettype wire
